// File: rtl/screen_seq_ctl.sv
// Screen sequencer: picks start/play/end screen for the VGA mux and runs the game logic.
// Screens switch only on a vblnk rising edge, so a frame is never torn.
module screen_seq_ctl #(
   parameter int DEBOUNCE_CYCLES = 650000,
   parameter int END_HOLD_FRAMES = 300
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vblnk,
   input  logic       btn_start,
   input  logic       game_over,
   input  logic [1:0] result_in,
   output logic [1:0] screen_sel,
   output logic       game_en,
   output logic       game_rst,
   output logic [1:0] result
);

   localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int END_W = (END_HOLD_FRAMES > 1) ? $clog2(END_HOLD_FRAMES) : 1;
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [END_W-1:0] END_LAST = END_W'(END_HOLD_FRAMES - 1);

   localparam logic [1:0] SEL_START = 2'd0;
   localparam logic [1:0] SEL_PLAY  = 2'd1;
   localparam logic [1:0] SEL_END   = 2'd2;

   typedef enum logic [2:0] {
      S_START,
      S_ARM_PLAY,
      S_PLAY,
      S_ARM_END,
      S_END
   } state_t;

   state_t           state;
   logic             btn_meta;
   logic             btn_sync;
   logic             btn_db;
   logic             btn_db_d;
   logic             vblnk_d;
   logic [DB_W-1:0]  db_cnt;
   logic [END_W-1:0] end_cnt;
   logic             start_evt;
   logic             frame_tick;

   // Button synchroniser, debounce and edge-detect registers; db_cnt tops out at DB_LAST.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         btn_db   <= 1'b0;
         btn_db_d <= 1'b0;
         vblnk_d  <= 1'b0;
         db_cnt   <= '0;
      end else begin
         btn_meta <= btn_start;
         btn_sync <= btn_meta;
         btn_db_d <= btn_db;
         vblnk_d  <= vblnk;
         if (btn_sync != btn_db) begin
            if (db_cnt == DB_LAST) begin
               btn_db <= btn_sync;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   assign start_evt  = btn_db & ~btn_db_d;
   assign frame_tick = vblnk & ~vblnk_d;

   // Screen FSM; case order gives game_over priority in S_PLAY and start_evt priority in S_END.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_START;
         screen_sel <= SEL_START;
         game_en    <= 1'b0;
         game_rst   <= 1'b0;
         result     <= 2'd0;
         end_cnt    <= '0;
      end else begin
         game_rst <= 1'b0;
         case (state)
            S_START: begin
               if (start_evt) state <= S_ARM_PLAY;
            end
            S_ARM_PLAY: begin
               if (frame_tick) begin
                  state      <= S_PLAY;
                  screen_sel <= SEL_PLAY;
                  game_rst   <= 1'b1;
                  result     <= 2'd0;
               end
            end
            S_PLAY: begin
               if (game_over) begin
                  result  <= result_in;
                  game_en <= 1'b0;
                  state   <= S_ARM_END;
               end else begin
                  game_en <= 1'b1;
               end
            end
            S_ARM_END: begin
               if (frame_tick) begin
                  state      <= S_END;
                  screen_sel <= SEL_END;
                  end_cnt    <= '0;
               end
            end
            S_END: begin
               if (start_evt) begin
                  state <= S_ARM_PLAY;
               end else if (frame_tick) begin
                  if (end_cnt == END_LAST) begin
                     state      <= S_START;
                     screen_sel <= SEL_START;
                  end else begin
                     end_cnt <= end_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state      <= S_START;
               screen_sel <= SEL_START;
               game_en    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/screen_seq_ctl.md
Name: screen_seq_ctl

Overview:
- Game-level screen sequencer that decides which screen pipeline drives the VGA output: start screen, play screen or end screen.
- Drives the select of the downstream screen mux, enables and resets the game logic, and latches the game result for the end-screen text drawers.
- Screen changes only on a vertical-blank boundary, so no frame is ever torn.
- Sits between the timing generator and the screen pipelines, next to the top-level mux.

Parameters:
- DEBOUNCE_CYCLES, 650000, clk cycles the synchronised button level must stay stable before it is accepted (10 ms at 65 MHz).
- END_HOLD_FRAMES, 300, frames the end screen is held before an automatic return to the start screen.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-low
- vblnk  in  1  vertical blank from the timing generator, synchronous to clk
- btn_start  in  1  raw start button, asynchronous to clk
- game_over  in  1  one-cycle pulse from game logic
- result_in  in  2  game result, valid with game_over (0 lose, 1 win, 2 draw)
- screen_sel  out  2  0 start, 1 play, 2 end; value 3 never driven
- game_en  out  1  game logic runs while high
- game_rst  out  1  one-cycle pulse, clears game state
- result  out  2  latched result for the end screen

Behaviour:
- Reset (rst low, asynchronous):
  - state S_START; screen_sel=0, game_en=0, game_rst=0, result=0.
  - Debounce counter, end-frame counter, synchroniser and edge registers all 0.
- Button path:
  - 2-FF synchroniser, then debounce.
  - Debounced level updates after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - start_evt is a 1-cycle pulse on the debounced rising edge.
  - Held button gives exactly one start_evt.
- frame_tick: 1-cycle pulse on the vblnk rising edge (registered edge detect).
- All outputs are registered.
- States and transitions:
  - S_START: screen_sel=0. start_evt -> S_ARM_PLAY.
  - S_ARM_PLAY: waits for frame_tick. On frame_tick -> S_PLAY; same-cycle register update sets screen_sel=1, game_rst=1 for that one cycle, result=0.
  - S_PLAY: game_en=1 (asserted the cycle after game_rst). game_over -> latch result_in into result, game_en=0 next cycle, -> S_ARM_END. start_evt ignored.
  - S_ARM_END: game_en=0, screen_sel stays 1. On frame_tick -> S_END, screen_sel=2, end counter=0.
  - S_END:
    - Each frame_tick increments the end counter.
    - When the counter reaches END_HOLD_FRAMES-1 and frame_tick occurs -> S_START, screen_sel=0 in the same update.
    - start_evt -> S_ARM_PLAY; result is held until game_rst.
- Simultaneous events:
  - start_evt and frame_tick in the same cycle in S_START: go to S_ARM_PLAY only; the switch happens on the next frame_tick, never the current one.
  - game_over and start_evt together in S_PLAY: game_over wins.
  - start_evt and the timeout frame_tick together in S_END: start_evt wins (-> S_ARM_PLAY).
  - game_over outside S_PLAY: ignored, result unchanged.
- Latency:
  - start_evt to screen_sel=1 is at most 1 frame plus 1 cycle.
  - game_over to game_en=0 is 1 cycle.
- Mid-operation reset: asynchronous return to the reset values in any state. No game_rst pulse is produced by reset.
- Counter widths are $clog2 of each parameter, minimum 1. Counters saturate and never wrap.

Test Plan (bench uses DEBOUNCE_CYCLES=4, END_HOLD_FRAMES=3, short frames):
- Reset check: release rst, no stimulus for 5 frames -> screen_sel=0, game_en=0, game_rst=0, result=0 throughout.
- Debounce: btn_start bounces 1-0-1 at 2-cycle spacing, then holds high for 10 cycles -> exactly one start_evt.
  - Next frame_tick: screen_sel=1 and a single-cycle game_rst.
  - Following cycle: game_en=1.
- Game end: in S_PLAY, game_over with result_in=1 -> game_en=0 one cycle later, result=1.
  - screen_sel stays 1 until the next frame_tick, then becomes 2.
- Timeout: no button in S_END -> screen_sel returns to 0 on the 3rd frame_tick after entry; result still 1.
- Restart from end: start_evt in S_END -> screen_sel=1 at the next frame_tick, with result=0 and the game_rst pulse.
- Collisions:
  - start_evt coincident with frame_tick in S_START -> screen_sel changes only at the following frame_tick.
  - game_over and start_evt together in S_PLAY -> end path taken.
  - rst low mid-S_PLAY -> outputs reset immediately.
